multdiv_iter: RTL and testbench

//  Iterative signed 32-bit multiply/divide unit for the processor execute stage.

---
 rtl/multdiv_pkg.sv | 25 ++
 rtl/multdiv_iter_counter.sv | 26 ++
 rtl/multdiv_iter.sv | 147 ++++++++++++++
 tb/tb_multdiv_iter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/multdiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: widths, FSM
// encodings, operation selects and the operand magnitude helper.
package multdiv_pkg;

    localparam int WIDTH = 32;
    localparam int CNT_W = 5;
    localparam logic [CNT_W-1:0] LAST_ITER = 5'd31;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN_MUL = 2'd1,
        ST_RUN_DIV = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    typedef enum logic {
        OP_MUL = 1'b0,
        OP_DIV = 1'b1
    } op_t;

    function automatic logic [WIDTH-1:0] abs32(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/multdiv_iter_counter.sv
// 5-bit iteration counter: synchronous load-zero, enable, async clear,
// with a terminal-count flag on the final iteration.
module multdiv_iter_counter
    import multdiv_pkg::*;
(
    input  logic clk,
    input  logic clr,
    input  logic i_load_zero,
    input  logic i_en,
    output logic o_last
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            r_count <= '0;
        else if (i_load_zero)
            r_count <= '0;
        else if (i_en)
            r_count <= r_count + 1'b1;
    end

    assign o_last = (r_count == LAST_ITER);

endmodule

// File: rtl/multdiv_iter.sv
// Iterative signed 32-bit multiply (radix-2 Booth) / divide (restoring on
// magnitudes with sign fix-up); 32 iterations per operation.
//
//  state      | meaning
//  -----------+-----------------------------------------------------------
//  ST_IDLE    | waiting for a start pulse
//  ST_RUN_MUL | one Booth step per edge, 32 steps
//  ST_RUN_DIV | one restoring-division step per edge, 32 steps
//  ST_DONE    | result/exception valid, rdy high; a new start is accepted
module multdiv_iter
    import multdiv_pkg::*;
(
    input  logic             clk,
    input  logic             clr,
    input  logic             i_ctrl_mult,
    input  logic             i_ctrl_div,
    input  logic [WIDTH-1:0] i_operand_a,
    input  logic [WIDTH-1:0] i_operand_b,
    output logic [WIDTH-1:0] o_result,
    output logic             o_exception,
    output logic             o_result_rdy,
    output logic             o_busy
);

    state_t            r_state;
    logic [64:0]       r_work;
    logic [WIDTH-1:0]  r_opnd;
    logic              r_neg;
    logic              r_div0;
    logic              r_ovf;

    logic              w_start;
    logic              w_running;
    logic              w_last;
    op_t               w_op;

    logic [32:0]       w_hi33;
    logic [32:0]       w_a33;
    logic [32:0]       w_booth;
    logic [64:0]       w_mul_next;

    logic [63:0]       w_rq;
    logic [32:0]       w_diff;
    logic [64:0]       w_div_next;

    assign w_running = (r_state == ST_RUN_MUL) || (r_state == ST_RUN_DIV);
    assign w_start   = ((r_state == ST_IDLE) || (r_state == ST_DONE)) &&
                       (i_ctrl_mult || i_ctrl_div);
    assign w_op      = i_ctrl_mult ? OP_MUL : OP_DIV;

    multdiv_iter_counter u_counter (
        .clk         (clk),
        .clr         (clr),
        .i_load_zero (w_start),
        .i_en        (w_running),
        .o_last      (w_last)
    );

    // Accumulator is carried at 33 bits so hi -/+ A cannot wrap when A = -2^31;
    // the extra sign bit is what the arithmetic shift brings into P[64].
    assign w_hi33 = {r_work[64], r_work[64:33]};
    assign w_a33  = {r_opnd[WIDTH-1], r_opnd};

    always_comb begin
        w_booth = w_hi33;
        case (r_work[1:0])
            2'b01:   w_booth = w_hi33 + w_a33;
            2'b10:   w_booth = w_hi33 - w_a33;
            default: w_booth = w_hi33;
        endcase
    end

    assign w_mul_next = {w_booth, r_work[32:1]};

    // Partial remainder stays below |B| <= 2^31, so the shifted value fits 32 bits.
    assign w_rq   = {r_work[62:0], 1'b0};
    assign w_diff = {1'b0, w_rq[63:32]} - {1'b0, r_opnd};

    always_comb begin
        if (!w_diff[32])
            w_div_next = {1'b0, w_diff[31:0], w_rq[31:1], 1'b1};
        else
            w_div_next = {1'b0, w_rq};
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state     <= ST_IDLE;
            r_work      <= '0;
            r_opnd      <= '0;
            r_neg       <= 1'b0;
            r_div0      <= 1'b0;
            r_ovf       <= 1'b0;
            o_result    <= '0;
            o_exception <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_start) begin
                        if (w_op == OP_MUL) begin
                            r_state <= ST_RUN_MUL;
                            r_work  <= {32'd0, i_operand_b, 1'b0};
                            r_opnd  <= i_operand_a;
                        end else begin
                            r_state <= ST_RUN_DIV;
                            r_work  <= {33'd0, abs32(i_operand_a)};
                            r_opnd  <= abs32(i_operand_b);
                            r_neg   <= i_operand_a[WIDTH-1] ^ i_operand_b[WIDTH-1];
                            r_div0  <= (i_operand_b == '0);
                            r_ovf   <= (i_operand_a == 32'h8000_0000) &&
                                       (i_operand_b == 32'hFFFF_FFFF);
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RUN_MUL: begin
                    r_work <= w_mul_next;
                    if (w_last) begin
                        r_state     <= ST_DONE;
                        o_result    <= w_mul_next[32:1];
                        o_exception <= (w_mul_next[64:33] != {32{w_mul_next[32]}});
                    end
                end
                ST_RUN_DIV: begin
                    r_work <= w_div_next;
                    if (w_last) begin
                        r_state <= ST_DONE;
                        if (r_div0) begin
                            o_result    <= '0;
                            o_exception <= 1'b1;
                        end else begin
                            o_result    <= r_neg ? (~w_div_next[31:0] + 32'd1)
                                                 : w_div_next[31:0];
                            o_exception <= r_ovf;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_result_rdy = (r_state == ST_DONE);
    assign o_busy       = w_running;

endmodule

// File: tb/tb_multdiv_iter.sv
// Directed and random checks of multdiv_iter against a plain-arithmetic model.
module tb_multdiv_iter;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        ctrl_mult = 1'b0;
    logic        ctrl_div = 1'b0;
    logic [31:0] operand_a = '0;
    logic [31:0] operand_b = '0;
    logic [31:0] result;
    logic        exception;
    logic        result_rdy;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multdiv_iter dut (
        .clk          (clk),
        .clr          (clr),
        .i_ctrl_mult  (ctrl_mult),
        .i_ctrl_div   (ctrl_div),
        .i_operand_a  (operand_a),
        .i_operand_b  (operand_b),
        .o_result     (result),
        .o_exception  (exception),
        .o_result_rdy (result_rdy),
        .o_busy       (busy)
    );

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Reference: signed arithmetic on 64-bit integers.
    task automatic ref_model(input bit mul, input logic [31:0] a, input logic [31:0] b,
                             output logic [31:0] r, output logic e);
        longint sa, sb, p;
        sa = $signed(a);
        sb = $signed(b);
        if (mul) begin
            p = sa * sb;
            r = p[31:0];
            e = (p != longint'($signed(p[31:0])));
        end else if (b == 32'd0) begin
            r = 32'd0;
            e = 1'b1;
        end else begin
            p = sa / sb;
            r = p[31:0];
            e = (p > 64'sd2147483647);
        end
    endtask

    function automatic logic [31:0] rand_opnd();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0: v = 32'd0;
            1: v = 32'h8000_0000;
            2: v = 32'hFFFF_FFFF;
            3: v = $urandom_range(0, 20);
            4: begin v = $urandom_range(1, 20); v = -v; end
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Called just after a rising edge with the unit idle or done; returns just after E0.
    task automatic start_op(input bit mul, input bit dv, input logic [31:0] a, input logic [31:0] b);
        ctrl_mult = mul;
        ctrl_div  = dv;
        operand_a = a;
        operand_b = b;
        @(posedge clk); #1;
        ctrl_mult = 1'b0;
        ctrl_div  = 1'b0;
        operand_a = $urandom;
        operand_b = $urandom;
    endtask

    // Runs edges E1..E32; optionally pulses a start at edge pulse_at while busy.
    task automatic finish_op(input string tag, input logic [31:0] exp_r, input logic exp_e,
                             input int pulse_at);
        int early;
        early = 0;
        for (int k = 1; k < 32; k++) begin
            if (k == pulse_at) ctrl_div = 1'b1;
            @(posedge clk); #1;
            ctrl_div = 1'b0;
            if (result_rdy !== 1'b0 || busy !== 1'b1) early++;
        end
        chk32({tag, "_busy_window"}, early, 0);
        @(posedge clk); #1;
        chk1({tag, "_rdy"}, result_rdy, 1'b1);
        chk1({tag, "_busy_done"}, busy, 1'b0);
        chk32({tag, "_result"}, result, exp_r);
        chk1({tag, "_exc"}, exception, exp_e);
    endtask

    task automatic check_drop(input string tag, input logic [31:0] exp_r, input logic exp_e);
        @(posedge clk); #1;
        chk1({tag, "_rdy_drop"}, result_rdy, 1'b0);
        chk32({tag, "_held"}, result, exp_r);
        chk1({tag, "_exc_held"}, exception, exp_e);
    endtask

    initial begin
        logic [31:0] a, b, er;
        logic        ee, m;
        int          rdy_seen;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk32("rst_result", result, 32'd0);
        chk1("rst_exc", exception, 1'b0);
        chk1("rst_rdy", result_rdy, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        @(negedge clk); clr = 1'b0;
        @(posedge clk); #1;

        // 1. 7 * -3
        start_op(1, 0, 32'd7, 32'hFFFF_FFFD);
        chk1("mul1_busy_e0", busy, 1'b1);
        finish_op("mul1", 32'hFFFF_FFEB, 1'b0, 0);
        check_drop("mul1", 32'hFFFF_FFEB, 1'b0);

        // 2. overflowing multiply
        start_op(1, 0, 32'h0001_0000, 32'h0001_0000);
        finish_op("mul_ovf", 32'd0, 1'b1, 0);
        check_drop("mul_ovf", 32'd0, 1'b1);

        // 3. signed divides
        start_op(0, 1, 32'hFFFF_FFF9, 32'd2);
        finish_op("div_neg", 32'hFFFF_FFFD, 1'b0, 0);
        check_drop("div_neg", 32'hFFFF_FFFD, 1'b0);
        start_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF);
        finish_op("div_min", 32'h8000_0000, 1'b1, 0);
        check_drop("div_min", 32'h8000_0000, 1'b1);

        // 4. divide by zero
        start_op(0, 1, 32'd5, 32'd0);
        finish_op("div0", 32'd0, 1'b1, 0);
        check_drop("div0", 32'd0, 1'b1);

        // 5. start while busy ignored; simultaneous starts choose multiply
        start_op(1, 0, 32'd6, 32'd7);
        finish_op("mul_ign", 32'd42, 1'b0, 5);
        check_drop("mul_ign", 32'd42, 1'b0);
        start_op(1, 1, 32'd6, 32'd7);
        finish_op("both", 32'd42, 1'b0, 0);
        check_drop("both", 32'd42, 1'b0);

        // 6. abort mid-operation
        start_op(1, 0, 32'd100, 32'd200);
        repeat (10) @(posedge clk);
        #1;
        chk1("abort_busy_e10", busy, 1'b1);
        clr = 1'b1;
        #1;
        chk32("abort_result", result, 32'd0);
        chk1("abort_exc", exception, 1'b0);
        chk1("abort_rdy", result_rdy, 1'b0);
        chk1("abort_busy", busy, 1'b0);
        @(negedge clk); clr = 1'b0;
        rdy_seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (result_rdy !== 1'b0 || busy !== 1'b0) rdy_seen++;
        end
        chk32("abort_no_rdy", rdy_seen, 0);

        // back-to-back: div started in the DONE cycle of the multiply
        start_op(1, 0, 32'd3, 32'd4);
        finish_op("b2b_mul", 32'd12, 1'b0, 0);
        start_op(0, 1, 32'd12, 32'd5);
        chk1("b2b_busy", busy, 1'b1);
        finish_op("b2b_div", 32'd2, 1'b0, 0);
        check_drop("b2b_div", 32'd2, 1'b0);

        // random operations against the arithmetic model
        for (int n = 0; n < 40; n++) begin
            m = (n % 2 == 0);
            a = rand_opnd();
            b = rand_opnd();
            ref_model(m, a, b, er, ee);
            start_op(m, !m, a, b);
            finish_op(m ? "rnd_mul" : "rnd_div", er, ee, 0);
            if (n % 4 == 3) check_drop("rnd", er, ee);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
